border_intrusion_ctrl_n: RTL and testbench
==========================================

# border_intrusion_ctrl_n

Parametrised N-zone intrusion controller for the border monitoring system. It is the next generation of the fixed 4-zone controller.
- Per-zone debounce, masking and a per-zone stuck-sensor (tamper) timer.
- Configurable escalation threshold and alert hold-off.
- Sticky zone indication cleared by operator acknowledge.
- Sits between the synchronised sensor inputs and the LED/annunciator drivers.

## Interface
- N_ZONES, 8: number of sensor zones (2..32)
- DEBOUNCE_CYC, 4: consecutive stable cycles before a zone input is accepted (≥1)
- TAMPER_CYC, 16: cycles a filtered zone may stay active before tamper is declared (> DEBOUNCE_CYC)
- HIGH_THRESH, 2: active-zone count at or above which HIGH_ALERT is entered (2..N_ZONES)
- HOLD_CYC, 8: cycles ALERT/HIGH_ALERT persist after all zones clear (≥1)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- arm  in  1  1 = armed; 0 forces DISARMED
- zone  in  N_ZONES  raw sensor bits, already synchronous to clk
- zone_mask  in  N_ZONES  1 = zone enabled; masked zones never count or tamper
- ack  in  1  operator acknowledge, one-cycle pulse
- safe_led  out  1  state is DISARMED or SAFE
- alert_led  out  1  state is ALERT
- high_alert_led  out  1  state is HIGH_ALERT
- tamper_led  out  1  state is TAMPER
- zone_led  out  N_ZONES  sticky record of zones seen active since last ack/disarm
- active_count  out  $clog2(N_ZONES+1)  popcount of qualified zones
- state_o  out  3  encoded FSM state
- event_pulse  out  1  one-cycle pulse on every state change

## Operation
- Per-zone debounce:
  - Counter runs while raw bit ≠ filtered bit.
  - Counter clears on any cycle where they are equal.
  - Filtered bit takes raw value on the DEBOUNCE_CYC-th consecutive differing edge.
- Qualified zone = filtered & zone_mask & arm. active_count = popcount(qualified).
- Tamper timer per zone:
  - Counts while qualified is 1, clears when 0.
  - Saturates at TAMPER_CYC; the zone's tamper flag is set while saturated.
- States: DISARMED, SAFE, ALERT, HIGH_ALERT, TAMPER.
- Transition priority, highest first:
  1. rst
  2. arm=0 → DISARMED from any state
  3. any tamper flag → TAMPER
  4. count-based rules below
- DISARMED → SAFE on arm=1.
- SAFE / ALERT / HIGH_ALERT: count ≥ HIGH_THRESH → HIGH_ALERT; 1 ≤ count < HIGH_THRESH → ALERT.
  - HIGH_ALERT de-escalates directly to ALERT when count drops.
- count = 0 in ALERT or HIGH_ALERT:
  - Hold counter loads HOLD_CYC-1 and state is retained.
  - Counter decrements each cycle; SAFE is entered when it expires.
  - Any count > 0 during hold cancels the hold and re-evaluates.
- TAMPER is latched. Exit to SAFE only on ack while count = 0 and no tamper flag is set; otherwise ack is ignored.
- zone_led[i] sets when qualified[i] = 1.
  - ack clears bits whose qualified bit is 0 at that cycle.
  - DISARMED clears all bits.
- ack has no effect on state outside TAMPER.

## Timing
- Reset values:
  - State DISARMED; safe_led=1; all other LEDs 0; zone_led=0.
  - active_count=0; state_o=DISARMED; event_pulse=0.
  - Filters, debounce, tamper and hold counters 0.
- All outputs are registered and decoded from the state register. No combinational input→output paths.
- Raw zone edge to LED change: DEBOUNCE_CYC+1 rising edges (filter update, then state update).
- Tamper: TAMPER_CYC+1 edges after the filtered bit rises.
- Disarm: LEDs show DISARMED on the first edge with arm=0, with no debounce.
- A raw glitch shorter than DEBOUNCE_CYC cycles has no visible effect.
- Reset mid-alert: all outputs return to reset values asynchronously. Debounce restarts from filtered=0.
- Simultaneous ack and new zone activation: the set wins for that bit.
- event_pulse is high in the cycle state_o first shows the new state.

## Structure
- Package border_intrusion_pkg holds:
  - State enum and its 3-bit encoding (DISARMED=0, SAFE=1, ALERT=2, HIGH_ALERT=3, TAMPER=4).
  - Count-width helper function.
- Sub-module zone_conditioner: one instance per zone.
  - Implements the debounce filter and the tamper timer.
  - Outputs filtered bit and tamper flag.
- Top level holds popcount, FSM, hold counter and zone_led register.

## Test plan
Defaults (N=8, D=4, T=16, H=2, HOLD=8) unless stated.
- Disarmed: arm=0, zone=0xFF for 20 cycles → safe_led=1, active_count=0, zone_led=0x00, state_o=0.
- Glitch filter: arm=1, zone=0x01 for 3 cycles then 0 → no state change. zone=0x01 held → alert_led=1 on 5th edge, zone_led=0x01.
- Escalation and hold:
  - zone 0x01 → 0x03: high_alert_led=1, count=2.
  - Back to 0x01: alert_led=1, no hold.
  - Then 0x00: alert persists, safe_led=1 exactly 4+8 edges after release.
- Mask: zone_mask=0xFE, zone=0x01 held 30 cycles → safe_led stays 1, no tamper.
- Tamper: zone=0x04 held 25 cycles → tamper_led=1 at edge 4+17.
  - ack while zone still high → stays TAMPER.
  - Release, then ack after 5 cycles → safe_led=1, zone_led=0x00.
- Disarm/reset mid-alert:
  - zone=0xFF, arm dropped → DISARMED next edge, zone_led=0.
  - Re-arm with zone=0xFF, then rst pulse → all outputs at reset values immediately.

Source files
------------

// File: rtl/border_intrusion_pkg.sv
// Shared types for the N-zone intrusion controller: FSM state encoding and width helpers.
// Latency: n/a (types only).  Backpressure: n/a.
package border_intrusion_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED   = 3'd0,
        ST_SAFE       = 3'd1,
        ST_ALERT      = 3'd2,
        ST_HIGH_ALERT = 3'd3,
        ST_TAMPER     = 3'd4
    } state_t;

    // Bits needed to hold a population count of n zones (0..n inclusive).
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/border_intrusion_ctrl_n_zone_conditioner.sv
// Per-zone debounce filter plus stuck-sensor (tamper) timer.
// Latency: filtered follows raw after DEBOUNCE_CYC stable edges; tamper after TAMPER_CYC qualified edges.
// Backpressure: none, free-running per cycle.
module zone_conditioner #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int TAMPER_CYC   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic enable,
    output logic filtered,
    output logic tamper
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int TW = $clog2(TAMPER_CYC + 1);

    logic [DW-1:0] db_cnt;
    logic [TW-1:0] tmp_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filtered <= 1'b0;
            db_cnt   <= '0;
            tmp_cnt  <= '0;
        end else begin
            if (raw == filtered) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE_CYC - 1)) begin
                filtered <= raw;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            // Ages only while the zone is qualified; saturates so the flag stays up.
            if (!(filtered && enable)) begin
                tmp_cnt <= '0;
            end else if (tmp_cnt != TW'(TAMPER_CYC)) begin
                tmp_cnt <= tmp_cnt + 1'b1;
            end
        end
    end

    assign tamper = (tmp_cnt == TW'(TAMPER_CYC));

endmodule

// File: rtl/border_intrusion_ctrl_n.sv
// N-zone intrusion controller: debounced zones, popcount escalation, alert hold-off, latched tamper.
// Latency: raw zone edge to LED change is DEBOUNCE_CYC+1 edges; disarm shows on the first edge.
// Backpressure: none; all outputs registered or decoded from the state register.
module border_intrusion_ctrl_n
    import border_intrusion_pkg::*;
#(
    parameter int N_ZONES      = 8,
    parameter int DEBOUNCE_CYC = 4,
    parameter int TAMPER_CYC   = 16,
    parameter int HIGH_THRESH  = 2,
    parameter int HOLD_CYC     = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                arm,
    input  logic [N_ZONES-1:0]                  zone,
    input  logic [N_ZONES-1:0]                  zone_mask,
    input  logic                                ack,
    output logic                                safe_led,
    output logic                                alert_led,
    output logic                                high_alert_led,
    output logic                                tamper_led,
    output logic [N_ZONES-1:0]                  zone_led,
    output logic [count_width(N_ZONES)-1:0]     active_count,
    output logic [2:0]                          state_o,
    output logic                                event_pulse
);

    localparam int CW = count_width(N_ZONES);
    localparam int HW = $clog2(HOLD_CYC + 1);

    logic [N_ZONES-1:0] filtered;
    logic [N_ZONES-1:0] tamper_flag;
    logic [N_ZONES-1:0] zone_en;
    logic [N_ZONES-1:0] qualified;
    logic [CW-1:0]      count;

    state_t        state, next_state;
    logic [HW-1:0] hold_cnt, hold_cnt_nxt;
    logic          hold_active, hold_active_nxt;

    assign zone_en   = zone_mask & {N_ZONES{arm}};
    assign qualified = filtered & zone_en;

    for (genvar g = 0; g < N_ZONES; g++) begin : g_zone
        zone_conditioner #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .TAMPER_CYC   (TAMPER_CYC)
        ) u_cond (
            .clk      (clk),
            .rst      (rst),
            .raw      (zone[g]),
            .enable   (zone_en[g]),
            .filtered (filtered[g]),
            .tamper   (tamper_flag[g])
        );
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < N_ZONES; i++) begin
            count = count + CW'(qualified[i]);
        end
    end

    always_comb begin
        next_state      = state;
        hold_active_nxt = 1'b0;
        hold_cnt_nxt    = hold_cnt;
        if (!arm) begin
            next_state = ST_DISARMED;
        end else if (|tamper_flag) begin
            next_state = ST_TAMPER;
        end else begin
            case (state)
                ST_DISARMED: next_state = ST_SAFE;
                ST_TAMPER: begin
                    if (ack && (count == '0)) next_state = ST_SAFE;
                end
                default: begin
                    if (count >= CW'(HIGH_THRESH)) begin
                        next_state = ST_HIGH_ALERT;
                    end else if (count != '0) begin
                        next_state = ST_ALERT;
                    end else if (state == ST_ALERT || state == ST_HIGH_ALERT) begin
                        // First clear cycle arms the hold; SAFE once HOLD_CYC clear cycles have elapsed.
                        if (!hold_active) begin
                            hold_active_nxt = 1'b1;
                            hold_cnt_nxt    = HW'(HOLD_CYC - 1);
                        end else if (hold_cnt <= HW'(1)) begin
                            next_state = ST_SAFE;
                        end else begin
                            hold_active_nxt = 1'b1;
                            hold_cnt_nxt    = hold_cnt - 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_DISARMED;
            hold_cnt     <= '0;
            hold_active  <= 1'b0;
            active_count <= '0;
            event_pulse  <= 1'b0;
            zone_led     <= '0;
        end else begin
            state        <= next_state;
            hold_cnt     <= hold_cnt_nxt;
            hold_active  <= hold_active_nxt;
            active_count <= count;
            event_pulse  <= (next_state != state);
            // ack drops only bits not currently qualified; a simultaneous set wins.
            if (!arm) begin
                zone_led <= '0;
            end else begin
                zone_led <= (zone_led & ~({N_ZONES{ack}} & ~qualified)) | qualified;
            end
        end
    end

    assign state_o        = state;
    assign safe_led       = (state == ST_DISARMED) || (state == ST_SAFE);
    assign alert_led      = (state == ST_ALERT);
    assign high_alert_led = (state == ST_HIGH_ALERT);
    assign tamper_led     = (state == ST_TAMPER);

endmodule

// File: tb/tb_border_intrusion_ctrl_n.sv
// Directed plus randomised bench for border_intrusion_ctrl_n against a rule-level reference model.
module tb_border_intrusion_ctrl_n;

    localparam int NZ   = 8;
    localparam int DC   = 4;
    localparam int TC   = 16;
    localparam int HT   = 2;
    localparam int HOLD = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0;
    logic [NZ-1:0] zone = '0;
    logic [NZ-1:0] zone_mask = '1;
    logic          ack = 1'b0;
    logic          safe_led, alert_led, high_alert_led, tamper_led, event_pulse;
    logic [NZ-1:0] zone_led;
    logic [3:0]    active_count;
    logic [2:0]    state_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: rule-level view of each zone and of the controller.
    bit         m_filt [NZ];
    int         m_run  [NZ];
    int         m_age  [NZ];
    int         m_state;
    int         m_zero;
    logic [7:0] m_zled;
    int         m_cnt;
    bit         m_ev;

    border_intrusion_ctrl_n #(
        .N_ZONES      (NZ),
        .DEBOUNCE_CYC (DC),
        .TAMPER_CYC   (TC),
        .HIGH_THRESH  (HT),
        .HOLD_CYC     (HOLD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .arm            (arm),
        .zone           (zone),
        .zone_mask      (zone_mask),
        .ack            (ack),
        .safe_led       (safe_led),
        .alert_led      (alert_led),
        .high_alert_led (high_alert_led),
        .tamper_led     (tamper_led),
        .zone_led       (zone_led),
        .active_count   (active_count),
        .state_o        (state_o),
        .event_pulse    (event_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NZ; i++) begin
            m_filt[i] = 1'b0;
            m_run[i]  = 0;
            m_age[i]  = 0;
        end
        m_state = 0;
        m_zero  = 0;
        m_zled  = '0;
        m_cnt   = 0;
        m_ev    = 1'b0;
    endtask

    task automatic check_model();
        chk("state", 32'(state_o), 32'(m_state));
        chk("safe_led", 32'(safe_led), 32'(m_state <= 1));
        chk("alert_led", 32'(alert_led), 32'(m_state == 2));
        chk("high_led", 32'(high_alert_led), 32'(m_state == 3));
        chk("tamper_led", 32'(tamper_led), 32'(m_state == 4));
        chk("zone_led", 32'(zone_led), 32'(m_zled));
        chk("count", 32'(active_count), 32'(m_cnt));
        chk("event", 32'(event_pulse), 32'(m_ev));
    endtask

    task automatic check_reset_values();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_safe", 32'(safe_led), 32'd1);
        chk("rst_other_leds", 32'({alert_led, high_alert_led, tamper_led}), 32'd0);
        chk("rst_zone_led", 32'(zone_led), 32'd0);
        chk("rst_count", 32'(active_count), 32'd0);
        chk("rst_event", 32'(event_pulse), 32'd0);
    endtask

    // One clock edge: advance the model from the inputs presented, then compare.
    task automatic tick();
        logic [7:0] q;
        int         c;
        bit         tf;
        bit         holding;
        int         nxt;
        q  = '0;
        tf = 1'b0;
        for (int i = 0; i < NZ; i++) begin
            q[i] = m_filt[i] & zone_mask[i] & arm;
            if (m_age[i] == TC) tf = 1'b1;
        end
        c       = $countones(q);
        holding = 1'b0;
        if (!arm)                nxt = 0;
        else if (tf)             nxt = 4;
        else if (m_state == 0)   nxt = 1;
        else if (m_state == 4)   nxt = (ack && c == 0) ? 1 : 4;
        else if (c >= HT)        nxt = 3;
        else if (c > 0)          nxt = 2;
        else if (m_state == 1)   nxt = 1;
        else begin
            // Alert persists for HOLD clear cycles; the very first clear cycle never exits.
            holding = 1'b1;
            m_zero++;
            nxt = (m_zero >= HOLD && m_zero > 1) ? 1 : m_state;
        end
        if (!holding || nxt == 1) m_zero = 0;
        m_ev    = (nxt != m_state);
        m_state = nxt;
        m_cnt   = c;
        if (!arm)     m_zled = '0;
        else if (ack) m_zled = q;
        else          m_zled = m_zled | q;
        for (int i = 0; i < NZ; i++) begin
            m_age[i] = q[i] ? ((m_age[i] < TC) ? m_age[i] + 1 : TC) : 0;
            if (zone[i] != m_filt[i]) begin
                m_run[i]++;
                if (m_run[i] == DC) begin
                    m_filt[i] = zone[i];
                    m_run[i]  = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;

        // Disarmed with every sensor active.
        arm  = 1'b0;
        zone = 8'hFF;
        ticks(20);
        chk("dis_safe", 32'(safe_led), 32'd1);
        chk("dis_count", 32'(active_count), 32'd0);
        chk("dis_zone_led", 32'(zone_led), 32'd0);
        chk("dis_state", 32'(state_o), 32'd0);
        zone = 8'h00;
        ticks(5);
        arm = 1'b1;
        tick();
        chk("arm_safe", 32'(state_o), 32'd1);
        chk("arm_event", 32'(event_pulse), 32'd1);

        // Glitch shorter than the debounce window, then a held zone.
        zone = 8'h01;
        ticks(3);
        zone = 8'h00;
        ticks(3);
        chk("glitch_state", 32'(state_o), 32'd1);
        zone = 8'h01;
        ticks(4);
        chk("alert_before", 32'(alert_led), 32'd0);
        tick();
        chk("alert_5th", 32'(alert_led), 32'd1);
        chk("alert_zled", 32'(zone_led), 32'h01);

        // Escalation, de-escalation, then hold-off.
        zone = 8'h03;
        ticks(5);
        chk("high_led", 32'(high_alert_led), 32'd1);
        chk("high_count", 32'(active_count), 32'd2);
        zone = 8'h01;
        ticks(5);
        chk("deesc_alert", 32'(alert_led), 32'd1);
        zone = 8'h00;
        ticks(11);
        chk("hold_alert", 32'(alert_led), 32'd1);
        tick();
        chk("hold_safe", 32'(safe_led), 32'd1);

        // Masked zone never counts or tampers.
        zone_mask = 8'hFE;
        zone      = 8'h01;
        ticks(30);
        chk("mask_safe", 32'(safe_led), 32'd1);
        chk("mask_tamper", 32'(tamper_led), 32'd0);
        zone = 8'h00;
        ticks(5);
        zone_mask = 8'hFF;

        // Stuck sensor becomes tamper; ack only exits once clear.
        zone = 8'h04;
        ticks(20);
        chk("tamper_early", 32'(tamper_led), 32'd0);
        tick();
        chk("tamper_at21", 32'(tamper_led), 32'd1);
        ticks(4);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("tamper_ack_held", 32'(state_o), 32'd4);
        zone = 8'h00;
        ticks(6);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("tamper_exit", 32'(safe_led), 32'd1);
        chk("tamper_zled", 32'(zone_led), 32'd0);

        // Disarm and reset mid-alert.
        zone = 8'hFF;
        ticks(5);
        arm = 1'b0;
        tick();
        chk("disarm_state", 32'(state_o), 32'd0);
        chk("disarm_zled", 32'(zone_led), 32'd0);
        arm = 1'b1;
        ticks(3);
        chk("rearm_high", 32'(high_alert_led), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        #1;
        rst = 1'b0;
        zone = 8'h00;
        ticks(3);

        // Randomised segments of stable inputs with sporadic ack and disarm.
        for (int s = 0; s < 60; s++) begin
            int len;
            len  = $urandom_range(1, 30);
            zone = 8'($urandom);
            if ($urandom_range(0, 3) == 0) zone_mask = 8'($urandom);
            arm = ($urandom_range(0, 9) != 0);
            for (int k = 0; k < len; k++) begin
                ack = ($urandom_range(0, 9) == 0);
                tick();
            end
            ack = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
